// File: rtl/poly_root_search.sv
// Brute-force search for the smallest x with A*x^2 + B*x + C == R (mod 2^W).
// Each candidate is evaluated by Horner's rule over four cycles on one shared add/mul ALU.
module poly_root_search #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         go,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] x_out,
  output logic         found,
  output logic         done,
  output logic         busy
);

  typedef enum logic [3:0] {
    StLoadA, StLoadAWait, StLoadB, StLoadBWait,
    StLoadC, StLoadCWait, StLoadR, StLoadRWait,
    StEval0, StEval1, StEval2, StEval3,
    StDone, StDoneWait
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, r_q, r_d;
  logic [W-1:0] x_q, x_d, t_q, t_d;
  logic [W-1:0] x_out_q, x_out_d;
  logic         found_q, found_d;

  logic [W-1:0] alu_a, alu_b, alu_y;
  logic         alu_mul;

  always_comb begin
    alu_y = alu_mul ? alu_a * alu_b : alu_a + alu_b;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    r_d     = r_q;
    x_d     = x_q;
    t_d     = t_q;
    x_out_d = x_out_q;
    found_d = found_q;
    alu_a   = t_q;
    alu_b   = x_q;
    alu_mul = 1'b0;
    case (state_q)
      StLoadA: begin
        a_d = data_in;
        if (go) state_d = StLoadAWait;
      end
      StLoadAWait: if (!go) state_d = StLoadB;
      StLoadB: begin
        b_d = data_in;
        if (go) state_d = StLoadBWait;
      end
      StLoadBWait: if (!go) state_d = StLoadC;
      StLoadC: begin
        c_d = data_in;
        if (go) state_d = StLoadCWait;
      end
      StLoadCWait: if (!go) state_d = StLoadR;
      StLoadR: begin
        r_d = data_in;
        if (go) state_d = StLoadRWait;
      end
      StLoadRWait: begin
        if (!go) begin
          state_d = StEval0;
          x_d     = '0;
        end
      end
      StEval0: begin
        alu_a   = a_q;
        alu_mul = 1'b1;
        t_d     = alu_y;
        state_d = StEval1;
      end
      StEval1: begin
        alu_b   = b_q;
        t_d     = alu_y;
        state_d = StEval2;
      end
      StEval2: begin
        alu_mul = 1'b1;
        t_d     = alu_y;
        state_d = StEval3;
      end
      StEval3: begin
        alu_b = c_q;
        if (alu_y == r_q) begin
          state_d = StDone;
          x_out_d = x_q;
          found_d = 1'b1;
        end else if (x_q == '1) begin
          // Exhausted all candidates; never wrap into a second pass.
          state_d = StDone;
          x_out_d = '0;
          found_d = 1'b0;
        end else begin
          x_d     = x_q + 1'b1;
          state_d = StEval0;
        end
      end
      StDone: if (go) state_d = StDoneWait;
      StDoneWait: begin
        if (!go) begin
          state_d = StLoadA;
          x_out_d = '0;
          found_d = 1'b0;
        end
      end
      default: state_d = StLoadA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StLoadA;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      r_q     <= '0;
      x_q     <= '0;
      t_q     <= '0;
      x_out_q <= '0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      r_q     <= r_d;
      x_q     <= x_d;
      t_q     <= t_d;
      x_out_q <= x_out_d;
      found_q <= found_d;
    end
  end

  // Gated by resetn so both flags read low while reset is held.
  assign busy  = resetn && (state_q inside {StEval0, StEval1, StEval2, StEval3});
  assign done  = resetn && (state_q inside {StDone, StDoneWait});
  assign x_out = x_out_q;
  assign found = found_q;

endmodule

// File: tb/tb_poly_root_search.sv
// Directed and randomized checks of poly_root_search against a brute-force polynomial model.
module tb_poly_root_search;

  logic       clk;
  logic       resetn;
  logic       go;
  logic [7:0] data_in;
  logic [7:0] x_out;
  logic       found;
  logic       done;
  logic       busy;

  int vectors = 0;
  int errs    = 0;

  poly_root_search #(.W(8)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .go      (go),
    .data_in (data_in),
    .x_out   (x_out),
    .found   (found),
    .done    (done),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scan every candidate with plain modular arithmetic; keep the first hit.
  task automatic model(input logic [7:0] a, b, c, r, output logic f, output logic [7:0] x);
    logic [7:0] v;
    logic [7:0] xi;
    f = 1'b0;
    x = 8'd0;
    for (int i = 0; i < 256; i++) begin
      xi = i[7:0];
      v  = a * xi * xi + b * xi + c;
      if (!f && v == r) begin
        f = 1'b1;
        x = xi;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_val(input logic [7:0] v, input bit hold);
    data_in = v;
    go      = 1'b1;
    step();
    if (hold) begin
      for (int i = 0; i < 19; i++) begin
        data_in = 8'($urandom);
        step();
      end
    end
    go      = 1'b0;
    data_in = 8'($urandom);
    step();
  endtask

  task automatic load_all(input logic [7:0] a, b, c, r, input bit hold);
    load_val(a, hold);
    load_val(b, hold);
    load_val(c, hold);
    load_val(r, hold);
  endtask

  task automatic run_search(input logic [7:0] a, b, c, r, input bit hold_load, hold_eval);
    logic       ef;
    logic [7:0] ex;
    int         lat;
    int         n;
    model(a, b, c, r, ef, ex);
    lat = ef ? 4 * (int'(ex) + 1) : 1024;
    load_all(a, b, c, r, hold_load);
    check("busy_in_eval0", int'(busy), 1);
    if (hold_eval) go = 1'b1;
    n = 0;
    while (!done && n < 1100) begin
      step();
      n++;
    end
    check("latency", n, lat);
    check("found", int'(found), int'(ef));
    check("x_out", int'(x_out), int'(ex));
    check("busy_in_done", int'(busy), 0);
    repeat (3) step();
    check("done_held", int'(done), 1);
    check("no_reentry_busy", int'(busy), 0);
    check("x_out_held", int'(x_out), int'(ex));
    go = 1'b1;
    step();
    check("done_in_wait", int'(done), 1);
    go = 1'b0;
    step();
    check("done_after_ack", int'(done), 0);
    check("found_cleared", int'(found), 0);
    check("x_out_cleared", int'(x_out), 0);
  endtask

  initial begin
    logic [7:0] a, b, c, r, x0;
    resetn  = 1'b0;
    go      = 1'b0;
    data_in = 8'd0;
    step();
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    step();
    check("reset_found", int'(found), 0);
    check("reset_x_out", int'(x_out), 0);
    resetn = 1'b1;

    run_search(8'd1, 8'd2, 8'd3, 8'd11, 1'b0, 1'b0);
    run_search(8'd5, 8'd7, 8'd9, 8'd9, 1'b0, 1'b0);
    run_search(8'h00, 8'h10, 8'h10, 8'h00, 1'b0, 1'b0);
    run_search(8'd0, 8'd1, 8'd0, 8'd255, 1'b0, 1'b0);
    run_search(8'd0, 8'd0, 8'd1, 8'd2, 1'b0, 1'b0);
    run_search(8'd1, 8'd2, 8'd3, 8'd11, 1'b1, 1'b0);
    run_search(8'h00, 8'h10, 8'h10, 8'h00, 1'b0, 1'b1);

    for (int k = 0; k < 6; k++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      c  = 8'($urandom);
      x0 = 8'($urandom);
      r  = (k < 4) ? 8'(a * x0 * x0 + b * x0 + c) : 8'($urandom);
      run_search(a, b, c, r, 1'($urandom), 1'($urandom));
    end

    // Reset during the second EVAL_1 cycle discards the search.
    load_all(8'd1, 8'd2, 8'd3, 8'd11, 1'b0);
    repeat (5) step();
    check("busy_before_reset", int'(busy), 1);
    resetn = 1'b0;
    step();
    check("midreset_done", int'(done), 0);
    check("midreset_found", int'(found), 0);
    check("midreset_x_out", int'(x_out), 0);
    check("midreset_busy", int'(busy), 0);
    resetn = 1'b1;
    run_search(8'd1, 8'd2, 8'd3, 8'd11, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
